// File: rtl/cycle_sequencer_pkg.sv
// rtl/cycle_sequencer_pkg.sv - shared step, state, prefix and IR field constants
package cycle_sequencer_pkg;

    localparam logic [3:0] T1 = 4'b0001;
    localparam logic [3:0] T2 = 4'b0010;
    localparam logic [3:0] T3 = 4'b0100;
    localparam logic [3:0] T4 = 4'b1000;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } seq_state_t;

    localparam logic [7:0] PREFIX_CB = 8'hCB;

    localparam int X_MSB = 7;
    localparam int X_LSB = 6;
    localparam int Y_MSB = 5;
    localparam int Y_LSB = 3;
    localparam int Z_MSB = 2;
    localparam int Z_LSB = 0;
    localparam int P_MSB = 5;
    localparam int P_LSB = 4;
    localparam int Q_BIT = 3;

endpackage

// File: rtl/cycle_sequencer_ir_field_decode.sv
// rtl/cycle_sequencer_ir_field_decode.sv - gated one-hot decode of the IR x/y/z/p/q fields
module ir_field_decode
    import cycle_sequencer_pkg::*;
(
    input  logic [7:0] i_IR,
    input  logic       i_Enable,
    output logic [3:0] o_X,
    output logic [7:0] o_Y,
    output logic [7:0] o_Z,
    output logic [3:0] o_P,
    output logic [1:0] o_Q
);

    always_comb begin
        o_X = '0;
        o_Y = '0;
        o_Z = '0;
        o_P = '0;
        o_Q = '0;
        if (i_Enable) begin
            o_X = 4'b0001 << i_IR[X_MSB:X_LSB];
            o_Y = 8'b0000_0001 << i_IR[Y_MSB:Y_LSB];
            o_Z = 8'b0000_0001 << i_IR[Z_MSB:Z_LSB];
            o_P = 4'b0001 << i_IR[P_MSB:P_LSB];
            o_Q = 2'b01 << i_IR[Q_BIT];
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - T-step / M-cycle sequencer with opcode latch and CB prefix tracking
module cycle_sequencer
    import cycle_sequencer_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic       i_Fetch,
    input  logic       i_Wait,
    input  logic [7:0] i_Bus_Data,
    output logic [3:0] o_Cycle_Step,
    output logic [7:0] o_Cycle_Count,
    output logic       o_Fetch_Cycle,
    output logic [7:0] o_IR,
    output logic       o_Prefix_CB,
    output logic [3:0] o_X,
    output logic [7:0] o_Y,
    output logic [7:0] o_Z,
    output logic [3:0] o_P,
    output logic [1:0] o_Q,
    output logic       o_Seq_Error
);

    seq_state_t r_state;
    logic [3:0] r_step;
    logic [7:0] r_count;
    logic [7:0] r_ir;
    logic       r_prefix_cb;
    logic       r_fetch_sticky;
    logic       r_seq_error;
    logic       w_end_instr;

    // A fetch request seen on T4 itself still ends the instruction this M-cycle.
    assign w_end_instr = r_fetch_sticky | i_Fetch;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state        <= ST_FETCH;
            r_step         <= T1;
            r_count        <= '0;
            r_ir           <= '0;
            r_prefix_cb    <= 1'b0;
            r_fetch_sticky <= 1'b0;
            r_seq_error    <= 1'b0;
        end else if (!i_Wait) begin
            r_step <= {r_step[2:0], r_step[3]};
            if (r_state == ST_FETCH && r_step == T3) begin
                r_ir <= i_Bus_Data;
            end
            if (r_state == ST_EXEC && r_step != T4) begin
                r_fetch_sticky <= r_fetch_sticky | i_Fetch;
            end
            if (r_step == T4) begin
                r_fetch_sticky <= 1'b0;
                if (r_state == ST_FETCH) begin
                    if (r_ir == PREFIX_CB && !r_prefix_cb) begin
                        r_prefix_cb <= 1'b1;
                    end else begin
                        r_state <= ST_EXEC;
                        r_count <= 8'b0000_0001;
                    end
                end else if (w_end_instr) begin
                    r_state     <= ST_FETCH;
                    r_count     <= '0;
                    r_prefix_cb <= 1'b0;
                end else if (r_count[7]) begin
                    // Runaway instruction: force a fetch rather than wrap the count.
                    r_state     <= ST_FETCH;
                    r_count     <= '0;
                    r_prefix_cb <= 1'b0;
                    r_seq_error <= 1'b1;
                end else begin
                    r_count <= {r_count[6:0], 1'b0};
                end
            end
        end
    end

    assign o_Cycle_Step  = r_step;
    assign o_Cycle_Count = r_count;
    assign o_Fetch_Cycle = (r_state == ST_FETCH);
    assign o_IR          = r_ir;
    assign o_Prefix_CB   = r_prefix_cb;
    assign o_Seq_Error   = r_seq_error;

    ir_field_decode u_ir_field_decode (
        .i_IR     (r_ir),
        .i_Enable (r_state == ST_EXEC),
        .o_X      (o_X),
        .o_Y      (o_Y),
        .o_Z      (o_Z),
        .o_P      (o_P),
        .o_Q      (o_Q)
    );

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb/tb_cycle_sequencer.sv - scoreboard bench for cycle_sequencer
module tb_cycle_sequencer;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       fetch  = 1'b0;
    logic       wait_i = 1'b0;
    logic [7:0] bus    = 8'h00;

    logic [3:0] o_step;
    logic [7:0] o_count;
    logic       o_fcyc;
    logic [7:0] o_ir;
    logic       o_pfx;
    logic [3:0] o_x;
    logic [7:0] o_y;
    logic [7:0] o_z;
    logic [3:0] o_p;
    logic [1:0] o_q;
    logic       o_err;

    cycle_sequencer dut (
        .i_Clk         (clk),
        .i_Reset_n     (rst_n),
        .i_Fetch       (fetch),
        .i_Wait        (wait_i),
        .i_Bus_Data    (bus),
        .o_Cycle_Step  (o_step),
        .o_Cycle_Count (o_count),
        .o_Fetch_Cycle (o_fcyc),
        .o_IR          (o_ir),
        .o_Prefix_CB   (o_pfx),
        .o_X           (o_x),
        .o_Y           (o_y),
        .o_Z           (o_z),
        .o_P           (o_p),
        .o_Q           (o_q),
        .o_Seq_Error   (o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic       fetch;
        logic [7:0] cnt;
        logic       pfx;
        logic       err;
        logic [7:0] ir;
        logic [3:0] x;
        logic [7:0] y;
        logic [7:0] z;
        logic [3:0] p;
        logic [1:0] q;
    } mrec_t;

    mrec_t sb[$];

    function automatic mrec_t rec_f(input logic pfx, input logic err);
        mrec_t r;
        r.fetch = 1'b1; r.cnt = 8'h00; r.pfx = pfx; r.err = err; r.ir = 8'h00;
        r.x = 4'h0; r.y = 8'h00; r.z = 8'h00; r.p = 4'h0; r.q = 2'b00;
        return r;
    endfunction

    function automatic mrec_t rec_e(input logic [7:0] cnt, input logic pfx, input logic err,
                                    input logic [7:0] ir, input logic [3:0] x, input logic [7:0] y,
                                    input logic [7:0] z, input logic [3:0] p, input logic [1:0] q);
        mrec_t r;
        r.fetch = 1'b0; r.cnt = cnt; r.pfx = pfx; r.err = err; r.ir = ir;
        r.x = x; r.y = y; r.z = z; r.p = p; r.q = q;
        return r;
    endfunction

    // One record per M-cycle, compared at its first T1 sample.
    logic  prev_t1 = 1'b1;
    mrec_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_t1 = 1'b1;
        end else begin
            if (o_step == 4'b0001 && !prev_t1) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("m_fetch_cycle", {31'd0, o_fcyc}, {31'd0, e.fetch});
                    check("m_count", {24'd0, o_count}, {24'd0, e.cnt});
                    check("m_prefix", {31'd0, o_pfx}, {31'd0, e.pfx});
                    check("m_seq_error", {31'd0, o_err}, {31'd0, e.err});
                    check("m_x", {28'd0, o_x}, {28'd0, e.x});
                    check("m_y", {24'd0, o_y}, {24'd0, e.y});
                    check("m_z", {24'd0, o_z}, {24'd0, e.z});
                    check("m_p", {28'd0, o_p}, {28'd0, e.p});
                    check("m_q", {30'd0, o_q}, {30'd0, e.q});
                    if (!e.fetch) check("m_ir", {24'd0, o_ir}, {24'd0, e.ir});
                end
            end
            prev_t1 = (o_step == 4'b0001);
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_step"}, {28'd0, o_step}, 32'h1);
        check({tag, "_count"}, {24'd0, o_count}, 32'h0);
        check({tag, "_fetch_cycle"}, {31'd0, o_fcyc}, 32'h1);
        check({tag, "_ir"}, {24'd0, o_ir}, 32'h0);
        check({tag, "_prefix"}, {31'd0, o_pfx}, 32'h0);
        check({tag, "_seq_error"}, {31'd0, o_err}, 32'h0);
        check({tag, "_decode"}, {6'd0, o_x, o_y, o_z, o_p, o_q}, 32'h0);
    endtask

    task automatic wait_drain(input string tag);
        int budget = 300;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check({tag, "_drain_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_count_t2(input string tag, input logic [7:0] cnt);
        int budget = 300;
        while (!(o_count == cnt && o_step == 4'b0010) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check({tag, "_wait_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int budget;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // Opcode 0x00 with fetch held high: alternating FETCH/EXEC.
        fetch = 1'b1;
        bus   = 8'h00;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(rec_e(8'h01, 1'b0, 1'b0, 8'h00, 4'b0001, 8'h01, 8'h01, 4'b0001, 2'b01));
            sb.push_back(rec_f(1'b0, 1'b0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("first_edge_step", {28'd0, o_step}, 32'h2);
        check("first_edge_fetch_cycle", {31'd0, o_fcyc}, 32'h1);
        wait_drain("alt");

        // Opcode 0x01, fetch pulsed only in the third EXEC M-cycle.
        fetch = 1'b0;
        bus   = 8'h01;
        sb.push_back(rec_e(8'h01, 1'b0, 1'b0, 8'h01, 4'b0001, 8'h01, 8'h02, 4'b0001, 2'b01));
        sb.push_back(rec_e(8'h02, 1'b0, 1'b0, 8'h01, 4'b0001, 8'h01, 8'h02, 4'b0001, 2'b01));
        sb.push_back(rec_e(8'h04, 1'b0, 1'b0, 8'h01, 4'b0001, 8'h01, 8'h02, 4'b0001, 2'b01));
        sb.push_back(rec_f(1'b0, 1'b0));
        wait_count_t2("op01", 8'h04);
        fetch = 1'b1;
        @(negedge clk);
        fetch = 1'b0;
        wait_drain("op01");

        // CB prefix followed by 0x37.
        fetch = 1'b1;
        bus   = 8'hCB;
        sb.push_back(rec_f(1'b1, 1'b0));
        sb.push_back(rec_e(8'h01, 1'b1, 1'b0, 8'h37, 4'b0001, 8'h40, 8'h80, 4'b1000, 2'b01));
        sb.push_back(rec_f(1'b0, 1'b0));
        budget = 100;
        while (!o_pfx && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("cb_prefix_timeout", 32'd1, 32'd0);
        bus = 8'h37;
        wait_drain("cb");

        // Wait freeze in EXEC T2, then run into the count overflow.
        fetch = 1'b0;
        bus   = 8'h00;
        for (int i = 0; i < 8; i++)
            sb.push_back(rec_e(8'h01 << i, 1'b0, 1'b0, 8'h00, 4'b0001, 8'h01, 8'h01, 4'b0001, 2'b01));
        sb.push_back(rec_f(1'b0, 1'b1));
        wait_count_t2("wait", 8'h01);
        wait_i = 1'b1;
        repeat (2) @(negedge clk);
        fetch = 1'b1;
        @(negedge clk);
        fetch = 1'b0;
        repeat (2) @(negedge clk);
        check("wait_step_frozen", {28'd0, o_step}, 32'h2);
        check("wait_count_frozen", {24'd0, o_count}, 32'h1);
        check("wait_still_exec", {31'd0, o_fcyc}, 32'h0);
        wait_i = 1'b0;
        wait_drain("overflow");
        check("overflow_error_sticky", {31'd0, o_err}, 32'h1);

        // Asynchronous reset in the third EXEC M-cycle of opcode 0x05.
        bus = 8'h05;
        for (int i = 0; i < 3; i++)
            sb.push_back(rec_e(8'h01 << i, 1'b0, 1'b1, 8'h05, 4'b0001, 8'h01, 8'h20, 4'b0001, 2'b01));
        wait_count_t2("midrst", 8'h04);
        check("midrst_drained", sb.size(), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        repeat (2) @(negedge clk);
        bus   = 8'h42;
        fetch = 1'b1;
        sb.push_back(rec_e(8'h01, 1'b0, 1'b0, 8'h42, 4'b0010, 8'h01, 8'h04, 4'b0001, 2'b01));
        sb.push_back(rec_f(1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        check("resume_step", {28'd0, o_step}, 32'h2);
        check("resume_fetch_cycle", {31'd0, o_fcyc}, 32'h1);
        wait_drain("resume");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have the port i_Clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have the port i_Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have the port i_Fetch, input, 1 bit: OR of the X-group decoder fetch requests; means "the current instruction ends after this M-cycle".
REQ-004 SHALL have the port i_Wait, input, 1 bit: bus stall; while high, all state holds.
REQ-005 SHALL have the port i_Bus_Data, input, 8 bits: opcode byte from the data bus.
REQ-006 SHALL have the port o_Cycle_Step, output, 4 bits: one-hot T-step (T1..T4) within the M-cycle.
REQ-007 SHALL have the port o_Cycle_Count, output, 8 bits: one-hot execute M-cycle index; all zeros during fetch.
REQ-008 SHALL have the port o_Fetch_Cycle, output, 1 bit: high for the whole of an opcode-fetch M-cycle.
REQ-009 SHALL have the port o_IR, output, 8 bits: the latched opcode.
REQ-010 SHALL have the port o_Prefix_CB, output, 1 bit: the current instruction is CB-prefixed.
REQ-011 SHALL have the ports o_X (4 bits), o_Y (8 bits), o_Z (8 bits), o_P (4 bits) and o_Q (2 bits), all outputs: one-hot decode of IR fields.
REQ-012 SHALL have the port o_Seq_Error, output, 1 bit: sticky flag, set when the M-cycle count overflows.

Function
REQ-013 o_Cycle_Step SHALL rotate 0001->0010->0100->1000->0001, one step per clock, whenever i_Wait=0.
REQ-014 While i_Wait=1, all registers SHALL hold their values and i_Fetch SHALL be ignored.
REQ-015 The sequencer SHALL have two states: FETCH and EXEC; state changes SHALL occur only on the clock edge that leaves T4 (o_Cycle_Step=1000).
REQ-016 In FETCH, on the T3 edge, the sequencer SHALL latch i_Bus_Data into IR.
REQ-017 On leaving T4 in FETCH, if IR=0xCB and o_Prefix_CB=0: set o_Prefix_CB and stay in FETCH. Otherwise: go to EXEC with o_Cycle_Count=0000_0001.
REQ-018 In EXEC, i_Fetch SHALL be captured into a sticky bit on any step of the M-cycle; the sticky bit SHALL clear at every M-cycle boundary.
REQ-019 On leaving T4 in EXEC with the sticky bit (or i_Fetch) set: go to FETCH, clear o_Cycle_Count and o_Prefix_CB.
REQ-020 On leaving T4 in EXEC without fetch: shift o_Cycle_Count left by one.
REQ-021 If o_Cycle_Count[7]=1 and there is no fetch, the sequencer SHALL go to FETCH, set o_Seq_Error and clear o_Prefix_CB (wrap protection).
REQ-022 Field decode SHALL be x=IR[7:6], y=IR[5:3], z=IR[2:0], p=IR[5:4], q=IR[3]; o_X/o_Y/o_Z/o_P/o_Q SHALL be the one-hot forms of these fields.
REQ-023 All decode outputs SHALL be forced to zero in FETCH, so no downstream decoder is active during a fetch.
REQ-024 Decode outputs SHALL be combinational from registered IR and state only, with zero added latency; they SHALL be valid from the first clock of EXEC.
REQ-025 o_Fetch_Cycle SHALL equal (state==FETCH).

Reset
REQ-026 While i_Reset_n=0: state=FETCH, o_Cycle_Step=0001, o_Cycle_Count=0, IR=0x00, o_Prefix_CB=0, sticky fetch=0, o_Seq_Error=0.
REQ-027 Assertion of i_Reset_n mid-instruction SHALL abandon that instruction immediately, with no partial IR update.
REQ-028 After release, the first rising edge SHALL advance to T2 of a FETCH cycle; o_Seq_Error SHALL clear only on reset.

Structure
REQ-029 A shared CPU package SHALL hold: the one-hot step constants T1..T4, the FETCH/EXEC state encoding, the CB prefix constant 8'hCB, and the field bit positions.
REQ-030 There SHALL be one sub-module, ir_field_decode: a combinational IR-to-one-hot decoder with a gate input.

Verification
REQ-031 Reset release, opcode 0x00 on the bus, i_Fetch tied to 1: SHALL produce an alternating FETCH/EXEC pattern; in EXEC o_X=0001, o_Z=0000_0001, o_Y=0000_0001, o_Cycle_Count=0000_0001.
REQ-032 Opcode 0x01 with i_Fetch asserted only in the third EXEC M-cycle: o_Cycle_Count SHALL step 01->02->04, then return to FETCH; o_P=0001 and o_Q=01 throughout.
REQ-033 Opcode 0xCB then 0x37: two FETCH cycles, then EXEC with o_Prefix_CB=1, o_X=0001, o_Y=0100_0000, o_Z=1000_0000; o_Prefix_CB SHALL clear at the next FETCH.
REQ-034 i_Wait held high for 5 clocks during T2 of EXEC: o_Cycle_Step and o_Cycle_Count SHALL freeze, and an i_Fetch pulse during the wait SHALL be ignored.
REQ-035 i_Fetch never asserted: after 8 EXEC M-cycles, the block SHALL return to FETCH and o_Seq_Error=1.
REQ-036 i_Reset_n pulsed low during EXEC M-cycle 3: outputs SHALL be at their reset values asynchronously, and the block SHALL resume from FETCH.
